// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch port and the data port.
// Data wins by default; a burst counter guarantees the fetch port a slot.
module mem_port_arbiter #(
  parameter int ADDR_BITWIDTH  = 32,
  parameter int WORD_BITWIDTH  = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int BUS_TIMEOUT    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_if_req,
  input  logic [ADDR_BITWIDTH-1:0] i_if_addr,
  output logic [WORD_BITWIDTH-1:0] o_if_rdata,
  output logic                     o_if_ready,
  output logic                     o_if_stall,
  input  logic                     i_mem_req,
  input  logic                     i_mem_we,
  input  logic [ADDR_BITWIDTH-1:0] i_mem_addr,
  input  logic [WORD_BITWIDTH-1:0] i_mem_wdata,
  output logic [WORD_BITWIDTH-1:0] o_mem_rdata,
  output logic                     o_mem_ready,
  output logic                     o_mem_stall,
  output logic                     o_bus_valid,
  output logic                     o_bus_we,
  output logic [ADDR_BITWIDTH-1:0] o_bus_addr,
  output logic [WORD_BITWIDTH-1:0] o_bus_wdata,
  input  logic [WORD_BITWIDTH-1:0] i_bus_rdata,
  input  logic                     i_bus_ready,
  output logic                     o_bus_err
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = $clog2(BUS_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_BUSY,
    S_MEM_BUSY
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_burst;
  logic [TW-1:0]   r_tmo;

  logic w_busy;
  logic w_tmo;
  logic w_fin;
  logic w_in_if;
  logic w_in_mem;
  logic w_starve;
  logic w_gnt_mem;
  logic w_gnt_if;

  // Completion and timeout detection; reset suppresses any ready pulse
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_in_if   = (r_state == S_IF_BUSY) && !i_rst;
    w_in_mem  = (r_state == S_MEM_BUSY) && !i_rst;
    w_tmo     = w_busy && !i_rst && !i_bus_ready
                && (r_tmo == TW'(BUS_TIMEOUT - 1));
    w_fin     = i_bus_ready || w_tmo;
    w_starve  = i_if_req && (r_burst == BW'(MAX_DATA_BURST));
    w_gnt_mem = i_mem_req && !w_starve;
    w_gnt_if  = i_if_req && !w_gnt_mem;
  end

  // Port-side responses; rdata is zero on timeout or when not completing
  always_comb begin
    o_if_ready  = w_in_if && i_if_req && w_fin;
    o_mem_ready = w_in_mem && i_mem_req && w_fin;
    o_if_rdata  = (w_in_if && i_bus_ready) ? i_bus_rdata : '0;
    o_mem_rdata = (w_in_mem && i_bus_ready) ? i_bus_rdata : '0;
    o_if_stall  = i_if_req && !o_if_ready;
    o_mem_stall = i_mem_req && !o_mem_ready;
    o_bus_err   = w_tmo;
  end

  // Arbitration FSM with registered bus outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_burst     <= '0;
      r_tmo       <= '0;
      o_bus_valid <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_gnt_mem) begin
            r_state     <= S_MEM_BUSY;
            o_bus_valid <= 1'b1;
            o_bus_we    <= i_mem_we;
            o_bus_addr  <= i_mem_addr;
            o_bus_wdata <= i_mem_wdata;
            if (!i_if_req)
              r_burst <= '0;
            else if (r_burst != BW'(MAX_DATA_BURST))
              r_burst <= r_burst + BW'(1);
          end else if (w_gnt_if) begin
            r_state     <= S_IF_BUSY;
            o_bus_valid <= 1'b1;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= i_if_addr;
            o_bus_wdata <= '0;
            r_burst     <= '0;
          end
        end
        S_IF_BUSY, S_MEM_BUSY: begin
          if (w_fin) begin
            r_state     <= S_IDLE;
            o_bus_valid <= 1'b0;
            o_bus_we    <= 1'b0;
            r_tmo       <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          o_bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a random
// latency bus responder, and a monitor with a grant-order reference.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int MB = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [WW-1:0] if_rdata;
  logic          if_ready;
  logic          if_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_stall;
  logic          bus_valid;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [WW-1:0] bus_wdata;
  logic [WW-1:0] bus_rdata;
  logic          bus_ready;
  logic          bus_err;

  mem_port_arbiter #(
    .ADDR_BITWIDTH (AW),
    .WORD_BITWIDTH (WW),
    .MAX_DATA_BURST(MB),
    .BUS_TIMEOUT   (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_rdata (if_rdata),
    .o_if_ready (if_ready),
    .o_if_stall (if_stall),
    .i_mem_req  (mem_req),
    .i_mem_we   (mem_we),
    .i_mem_addr (mem_addr),
    .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata),
    .o_mem_ready(mem_ready),
    .o_mem_stall(mem_stall),
    .o_bus_valid(bus_valid),
    .o_bus_we   (bus_we),
    .o_bus_addr (bus_addr),
    .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata),
    .i_bus_ready(bus_ready),
    .o_bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [WW-1:0] wdata;
    logic [WW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  int   lat_tab[logic [AW-1:0]];
  byte  gseq[$];

  int total = 0;
  int bad   = 0;
  int if_k  = 0;
  int mem_k = 0;
  bit bus_auto = 1'b1;
  bit mon_en   = 1'b0;

  function automatic logic [WW-1:0] fmix(logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 1 + $urandom_range(0, 3);
    if (r == 7) return TO;
    return TO + 1 + $urandom_range(0, 3);
  endfunction

  // Bus slave: answers after a per-address latency; >TO means never
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus_auto) begin
      if (!bus_valid) begin
        rcnt      = 0;
        bus_ready = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end else begin
        int lat;
        rcnt++;
        lat = lat_tab.exists(bus_addr) ? lat_tab[bus_addr] : 1;
        bus_ready = (rcnt == lat);
        bus_rdata = bus_ready ? fmix(bus_addr) : $urandom;
      end
    end
  end

  // Monitor: scoreboard pops, bus protocol and grant-order reference
  bit            prev_valid = 0;
  bit            prev_done  = 0;
  logic [AW-1:0] prev_addr;
  logic          prev_we;
  logic [WW-1:0] prev_wdata;
  int            vcnt  = 0;
  int            burst = 0;
  bit            g_pend = 0;
  byte           g_port;
  logic [AW-1:0] g_addr;
  logic          g_we;
  logic [WW-1:0] g_wdata;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (g_pend) begin
        chk("grant_valid", 32'(bus_valid), 32'd1);
        chk("grant_addr", bus_addr, g_addr);
        chk("grant_we", 32'(bus_we), 32'(g_we));
        if (g_we) chk("grant_wdata", bus_wdata, g_wdata);
        gseq.push_back(g_port);
        g_pend = 0;
      end else if (!prev_valid && bus_valid) begin
        chk("spurious_grant", 32'(bus_valid), 32'd0);
      end
      if (prev_valid && bus_valid && !prev_done) begin
        chk("hold_addr", bus_addr, prev_addr);
        chk("hold_we", 32'(bus_we), 32'(prev_we));
        chk("hold_wdata", bus_wdata, prev_wdata);
      end
      if (prev_done) chk("idle_gap", 32'(bus_valid), 32'd0);
      vcnt = bus_valid ? vcnt + 1 : 0;
      if (if_ready && mem_ready) chk("both_ready", 32'd1, 32'd0);
      if (!bus_valid && (if_ready || mem_ready))
        chk("ready_idle", 32'(if_ready || mem_ready), 32'd0);
      if (bus_err && !(if_ready || mem_ready))
        chk("err_no_ready", 32'(bus_err), 32'd0);
      chk("if_stall", 32'(if_stall), 32'(if_req && !if_ready));
      chk("mem_stall", 32'(mem_stall), 32'(mem_req && !mem_ready));
      if (if_ready) begin
        if (if_q.size() == 0) begin
          chk("if_q_under", 32'd1, 32'd0);
        end else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_addr", bus_addr, e.addr);
          chk("if_err", 32'(bus_err), 32'(e.err));
          if (e.err) chk("if_tmo_cycle", 32'(vcnt), 32'(TO));
        end
      end
      if (mem_ready) begin
        if (mem_q.size() == 0) begin
          chk("mem_q_under", 32'd1, 32'd0);
        end else begin
          e = mem_q.pop_front();
          chk("mem_rdata", mem_rdata, e.rdata);
          chk("mem_addr", bus_addr, e.addr);
          chk("mem_we", 32'(bus_we), 32'(e.we));
          chk("mem_err", 32'(bus_err), 32'(e.err));
          if (e.err) chk("mem_tmo_cycle", 32'(vcnt), 32'(TO));
        end
      end
      if (!bus_valid) begin
        if (mem_req && !(if_req && burst == MB)) begin
          g_pend  = 1;
          g_port  = "D";
          g_addr  = mem_addr;
          g_we    = mem_we;
          g_wdata = mem_wdata;
          burst   = if_req ? ((burst < MB) ? burst + 1 : burst) : 0;
        end else if (if_req) begin
          g_pend  = 1;
          g_port  = "F";
          g_addr  = if_addr;
          g_we    = 1'b0;
          g_wdata = '0;
          burst   = 0;
        end
      end
      prev_valid = bus_valid;
      prev_done  = if_ready || mem_ready;
      prev_addr  = bus_addr;
      prev_we    = bus_we;
      prev_wdata = bus_wdata;
    end
  end

  task automatic run_if(int n, int gmax, bit fast);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   lat;
      int   t;
      if_req = 1'b0;
      repeat ($urandom_range(0, gmax)) begin
        @(posedge clk);
        #1;
      end
      e.addr  = 32'h1000 + 32'(if_k) * 4;
      if_k++;
      lat     = fast ? 1 : pick_lat();
      lat_tab[e.addr] = lat;
      e.we    = 1'b0;
      e.wdata = '0;
      e.err   = (lat > TO);
      e.rdata = e.err ? '0 : fmix(e.addr);
      if_q.push_back(e);
      if_addr = e.addr;
      if_req  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!if_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!if_ready) chk("if_wait_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
  endtask

  task automatic run_mem(int n, int gmax, bit fast);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   lat;
      int   t;
      mem_req = 1'b0;
      repeat ($urandom_range(0, gmax)) begin
        @(posedge clk);
        #1;
      end
      e.addr  = 32'h8000 + 32'(mem_k) * 4;
      mem_k++;
      lat     = fast ? 1 : pick_lat();
      lat_tab[e.addr] = lat;
      e.we    = 1'($urandom_range(0, 1));
      e.wdata = $urandom;
      e.err   = (lat > TO);
      e.rdata = e.err ? '0 : fmix(e.addr);
      mem_q.push_back(e);
      mem_addr  = e.addr;
      mem_we    = e.we;
      mem_wdata = e.wdata;
      mem_req   = 1'b1;
      t = 0;
      @(negedge clk);
      while (!mem_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!mem_ready) chk("mem_wait_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    mem_req = 1'b0;
  endtask

  byte exp_g[10] = '{"D", "D", "D", "D", "F", "D", "D", "D", "D", "F"};

  initial begin
    rst       = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    if_req = 1'b0;
    mon_en = 1'b1;

    fork
      run_if(20, 3, 1'b0);
      run_mem(24, 3, 1'b0);
    join
    repeat (3) @(posedge clk);
    #1;

    gseq.delete();
    fork
      run_if(3, 0, 1'b1);
      run_mem(10, 0, 1'b1);
    join
    chk("gseq_len", 32'(gseq.size() >= 10), 32'd1);
    if (gseq.size() >= 10)
      for (int i = 0; i < 10; i++)
        chk("grant_order", 32'(gseq[i]), 32'(exp_g[i]));
    repeat (3) @(posedge clk);
    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);

    mon_en   = 1'b0;
    bus_auto = 1'b0;
    #1;
    bus_ready = 1'b0;
    @(posedge clk);
    #1;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h9000;
    @(negedge clk);
    chk("rt_pre_valid", 32'(bus_valid), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rt_busy", 32'(bus_valid), 32'd1);
    chk("rt_no_ready", 32'(mem_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus_ready = 1'b0;
    mem_req   = 1'b0;
    @(negedge clk);
    chk("rt_valid_low", 32'(bus_valid), 32'd0);
    chk("rt_addr_clr", bus_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
